// File: rtl/mac_pkg.sv
// Shared types and sizes for the MAC result path.
//   MAC_DATA_W     : width of a MAC result.
//   mac_data_t     : one MAC result word.
//   MAC_FIFO_DEPTH : default number of result FIFO entries.
package mac_pkg;

  localparam int unsigned MAC_DATA_W     = 32;
  localparam int unsigned MAC_FIFO_DEPTH = 4;

  typedef logic [MAC_DATA_W-1:0] mac_data_t;

endpackage

// File: rtl/mac_fifo_mem.sv
// Result storage for mac_result_fifo: DEPTH x DATA_W register array with a
// synchronous write port and an asynchronous read port. The array has no reset.
// Ports:
//   clk     : rising-edge clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational from i_raddr)
import mac_pkg::*;

module mac_fifo_mem #(
  parameter  int unsigned DATA_W = MAC_DATA_W,
  parameter  int unsigned DEPTH  = MAC_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mac_result_fifo.sv
// First-word-fall-through FIFO that captures every result from the a*b+c MAC
// stage and re-presents it to a valid/ready consumer. The producer cannot be
// stalled, so a result arriving while full with no pop is dropped and the
// sticky overflow flag is raised.
// Optional build macro: MAC_RESULT_FIFO_STATS_EN adds drop_cnt and hwm.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   validi    : result strobe from the MAC stage
//   data_in   : result from the MAC stage
//   readyi    : consumer ready
//   clr_ovf   : clear sticky overflow (a same-cycle drop wins)
//   valido    : head entry valid
//   data_out  : head entry, 0 while empty
//   full      : count == DEPTH
//   empty     : count == 0
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, at least one result was dropped
//   drop_cnt  : (stats) saturating drop counter, cleared by clr_ovf
//   hwm       : (stats) maximum occupancy since reset
import mac_pkg::*;

module mac_result_fifo #(
  parameter  int unsigned DATA_W = MAC_DATA_W,
  parameter  int unsigned DEPTH  = MAC_FIFO_DEPTH,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validi,
  input  logic [DATA_W-1:0] data_in,
  input  logic              readyi,
  input  logic              clr_ovf,
  output logic              valido,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow
`ifdef MAC_RESULT_FIFO_STATS_EN
  ,
  output logic [15:0]       drop_cnt,
  output logic [AW:0]       hwm
`endif
);

  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;

  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic              w_drop;
  logic [DATA_W-1:0] w_rdata;

  // Status is decoded from the registered occupancy only
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // A pop frees the slot the push needs, so a full FIFO still accepts on pop
  assign w_pop  = !w_empty && readyi;
  assign w_push = validi && (!w_full || w_pop);
  assign w_drop = validi && w_full && !readyi;

  mac_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wr_ptr),
    .i_wdata (data_in),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  // Pointers and occupancy; pointers wrap naturally over AW bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Sticky overflow; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clr_ovf) r_overflow <= 1'b0;
  end

`ifdef MAC_RESULT_FIFO_STATS_EN
  logic [15:0]   r_drop_cnt;
  logic [CW-1:0] r_hwm;

  // Saturating drop counter; clearing alongside a drop leaves one recorded
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             r_drop_cnt <= '0;
    else if (clr_ovf)                    r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
    else if (w_drop && !(&r_drop_cnt))   r_drop_cnt <= r_drop_cnt + 16'd1;
  end

  // High-water mark tracks the registered count, so it lags count by a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  r_hwm <= '0;
    else if (r_count > r_hwm) r_hwm <= r_count;
  end

  assign drop_cnt = r_drop_cnt;
  assign hwm      = r_hwm;
`endif

  assign valido   = !w_empty;
  assign data_out = w_empty ? '0 : w_rdata;
  assign full     = w_full;
  assign empty    = w_empty;
  assign count    = r_count;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_mac_result_fifo.sv
// Bench for mac_result_fifo: directed scenarios plus random traffic, each
// cycle compared against a queue-based reference of the FIFO's behaviour.
module tb_mac_result_fifo;
  import mac_pkg::*;

  localparam int unsigned DEPTH = MAC_FIFO_DEPTH;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst;
  logic        validi;
  mac_data_t   data_in;
  logic        readyi;
  logic        clr_ovf;
  logic        valido;
  mac_data_t   data_out;
  logic        full;
  logic        empty;
  logic [AW:0] count;
  logic        overflow;
`ifdef MAC_RESULT_FIFO_STATS_EN
  logic [15:0] drop_cnt;
  logic [AW:0] hwm;
`endif

  mac_result_fifo dut (
    .clk      (clk),
    .rst      (rst),
    .validi   (validi),
    .data_in  (data_in),
    .readyi   (readyi),
    .clr_ovf  (clr_ovf),
    .valido   (valido),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
`ifdef MAC_RESULT_FIFO_STATS_EN
    ,
    .drop_cnt (drop_cnt),
    .hwm      (hwm)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: contents in arrival order plus flags
  mac_data_t m_q[$];
  bit        m_ovf;
  int        m_drop;
  int        m_hwm;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
    m_hwm  = 0;
  endtask

  task automatic check_state(input string tag);
    mac_data_t head;
    head = (m_q.size() != 0) ? m_q[0] : '0;
    chk({tag, "_valido"},   32'(valido),   32'(m_q.size() != 0));
    chk({tag, "_data"},     32'(data_out), 32'(head));
    chk({tag, "_count"},    32'(count),    32'(m_q.size()));
    chk({tag, "_full"},     32'(full),     32'(m_q.size() == DEPTH));
    chk({tag, "_empty"},    32'(empty),    32'(m_q.size() == 0));
    chk({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
`ifdef MAC_RESULT_FIFO_STATS_EN
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    chk({tag, "_hwm"},      32'(hwm),      32'(m_hwm));
`endif
  endtask

  // Apply one cycle of inputs, advance the reference across the edge, compare
  task automatic cycle(input logic v, input mac_data_t d, input logic r,
                       input logic c, input string tag);
    int  n;
    bit  m_full, pop, push, drop;
    validi  = v;
    data_in = d;
    readyi  = r;
    clr_ovf = c;
    n      = m_q.size();
    m_full = (n == DEPTH);
    pop    = (n > 0) && r;
    push   = v && (!m_full || pop);
    drop   = v && m_full && !r;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (pop)  void'(m_q.pop_front());
      if (push) m_q.push_back(d);
      if (drop)   m_ovf = 1'b1;
      else if (c) m_ovf = 1'b0;
      if (c)                         m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
      if (n > m_hwm) m_hwm = n;
    end
    check_state(tag);
  endtask

  initial begin
    rst     = 1'b1;
    validi  = 1'b0;
    data_in = '0;
    readyi  = 1'b0;
    clr_ovf = 1'b0;
    model_reset();
    #1;
    check_state("t1_rst0");

    // 1: reset held with a strobing producer, then released idle
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h55, 1'b0, 1'b0, "t1_hold");
    rst = 1'b0;
    cycle(1'b0, 32'h0, 1'b0, 1'b0, "t1_rel");

    // 2: single transfer, presented one edge after push
    cycle(1'b1, 32'd42, 1'b1, 1'b0, "t2_push");
    chk("t2_head", 32'(data_out), 32'd42);
    cycle(1'b0, 32'd0, 1'b1, 1'b0, "t2_pop");
    chk("t2_empty", 32'(empty), 32'd1);

    // 3: fill while stalled, drop a fifth, drain in order
    for (int i = 1; i <= 4; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, "t3_fill");
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_head", 32'(data_out), 32'd1);
    cycle(1'b1, 32'd5, 1'b0, 1'b0, "t3_drop");
    chk("t3_ovf", 32'(overflow), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("t3_order", 32'(data_out), 32'(i));
      cycle(1'b0, 32'd0, 1'b1, 1'b0, "t3_drain");
    end
    chk("t3_empty", 32'(empty), 32'd1);
    cycle(1'b0, 32'd0, 1'b0, 1'b1, "t3_clr");

    // 4: full with simultaneous push and pop
    for (int i = 10; i <= 13; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, "t4_fill");
    cycle(1'b1, 32'd14, 1'b1, 1'b0, "t4_pp");
    chk("t4_count", 32'(count), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 11; i <= 14; i++) begin
      chk("t4_order", 32'(data_out), 32'(i));
      cycle(1'b0, 32'd0, 1'b1, 1'b0, "t4_drain");
    end

    // 5: drop coinciding with clear keeps overflow set
    for (int i = 20; i <= 23; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0, "t5_fill");
    cycle(1'b1, 32'd24, 1'b0, 1'b0, "t5_drop");
    cycle(1'b1, 32'd25, 1'b0, 1'b1, "t5_clrdrop");
    chk("t5_ovf_set", 32'(overflow), 32'd1);
`ifdef MAC_RESULT_FIFO_STATS_EN
    chk("t5_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("t5_hwm", 32'(hwm), 32'd4);
`endif
    cycle(1'b0, 32'd0, 1'b0, 1'b1, "t5_clr");
    chk("t5_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1, 1'b0, "t5_drain");

    // 6: interleaved traffic wrapping the pointers, then reset mid-drain
    for (int i = 0; i < 7; i++) cycle(1'b1, 32'(100 + i), logic'(i % 2), 1'b0, "t6_wrap");
    cycle(1'b0, 32'd0, 1'b1, 1'b0, "t6_drain");
    cycle(1'b0, 32'd0, 1'b1, 1'b0, "t6_drain");
    chk("t6_count2", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    model_reset();
    check_state("t6_async");
    cycle(1'b1, 32'd77, 1'b1, 1'b0, "t6_hold");
    rst = 1'b0;
    cycle(1'b1, 32'd99, 1'b0, 1'b0, "t6_after");
    chk("t6_head", 32'(data_out), 32'd99);
    chk("t6_cnt1", 32'(count), 32'd1);

    // Random traffic: bursty producer, random consumer, occasional clears
    for (int i = 0; i < 600; i++) begin
      logic v, r, c;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 45);
      c = ($urandom_range(0, 99) < 5);
      cycle(v, mac_data_t'($urandom()), r, c, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_result_fifo.md
Name: mac_result_fifo

Overview:
- Downstream stage of the a*b+c multiply-accumulate block.
- Captures each result that block produces (its valido/data_out pair) into a small first-word-fall-through FIFO.
- Re-presents results to the consumer with a valid/ready handshake.
- The producer has no backpressure, so this block absorbs bursts and flags any result it has to drop.

Parameters:
- DATA_W, 32, result width; matches the producer's data_out.
- DEPTH, 4, number of entries; must be a power of two and at least 2.
- AW, $clog2(DEPTH), pointer width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- validi  input  1  result strobe from the MAC stage (its valido).
- data_in  input  DATA_W  result from the MAC stage (its data_out).
- readyi  input  1  consumer ready.
- clr_ovf  input  1  clears the sticky overflow flag.
- valido  output  1  head entry valid.
- data_out  output  DATA_W  head entry.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  AW+1  occupancy, 0..DEPTH.
- overflow  output  1  sticky: at least one result was dropped.

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0, count = 0, overflow = 0.
  - valido = 0, empty = 1, full = 0, data_out = 0.
  - Memory contents are not cleared.
- Definitions:
  - pop = valido && readyi.
  - push = validi && (!full || pop).
  - drop = validi && full && !readyi.
- Push: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural wrap of AW bits).
- Pop: rd_ptr increments modulo DEPTH.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- valido = !empty, combinational from registered count.
- data_out = mem[rd_ptr] when valido, else 0. data_out is never X while empty.
- Latency: a result pushed at edge N is presented on valido/data_out in the cycle after edge N. There is no same-cycle bypass when empty.
- Simultaneous push and pop:
  - Partially filled: both occur and count is unchanged.
  - Full with readyi = 1: the push is accepted and count stays DEPTH.
  - Empty: only the push happens, because pop requires valido.
- Full without pop: the incoming result is discarded. Pointers, count and memory are unchanged, and overflow is set at the next edge.
- overflow clearing: clr_ovf clears it at the next edge. If clr_ovf and drop occur in the same cycle, set wins.
- Handshake: valido never deasserts and data_out never changes while valido = 1 && readyi = 0, except under reset.
- readyi is ignored while empty.
- Reset mid-operation: all queued results are lost immediately; outputs go to reset values asynchronously.
- Invariants:
  - full and empty are never both 1.
  - count == (wr_ptr - rd_ptr) mod DEPTH, or DEPTH when full.

Optional Feature:
- Macro: MAC_RESULT_FIFO_STATS_EN.
- When defined, adds two outputs:
  - drop_cnt, 16-bit: increments on each drop and saturates at 16'hFFFF. Cleared by rst and by clr_ovf; if clr_ovf coincides with a drop, drop_cnt = 1.
  - hwm, AW+1 bits: maximum count reached since reset, updated the cycle after count changes.
- When undefined, neither port nor its logic exists, and behaviour is otherwise identical.

Decomposition:
- Package mac_pkg holds:
  - localparam MAC_DATA_W = 32.
  - typedef logic [MAC_DATA_W-1:0] mac_data_t.
  - localparam MAC_FIFO_DEPTH = 4.
- One natural sub-module, mac_fifo_mem:
  - DEPTH x DATA_W register array with a synchronous write port and an asynchronous read port.
  - It has no reset.
- Pointer, count and flag logic stay in mac_result_fifo.

Test Plan:
1. Reset/empty: hold rst = 1 for 3 cycles with validi = 1, data_in = 32'h55 -> valido = 0, data_out = 0, empty = 1, count = 0 throughout. Release with validi = 0 -> state unchanged.
2. Single transfer: readyi = 1; validi pulses with data_in = 42 at edge 1 -> valido = 1, data_out = 42 after edge 1; popped at edge 2; empty = 1 after edge 2.
3. Fill and stall: readyi = 0; push 1, 2, 3, 4 on consecutive edges -> full = 1, count = 4, data_out = 1 held. Push 5 -> dropped and overflow = 1. Then readyi = 1 -> outputs 1, 2, 3, 4 in order, 5 never appears.
4. Full with simultaneous push and pop: FIFO full with 10, 11, 12, 13; readyi = 1 and push 14 in the same cycle -> count stays 4, overflow stays 0. Drain order is 11, 12, 13, 14.
5. Overflow priority: overflow = 1, full, readyi = 0, clr_ovf = 1 and validi = 1 in the same cycle -> overflow remains 1. The next cycle clr_ovf = 1 with validi = 0 -> overflow = 0. With MAC_RESULT_FIFO_STATS_EN defined: drop_cnt = 1, hwm = 4.
6. Reset mid-drain plus wrap: push 7 results with interleaved pops so the pointers wrap past DEPTH -> order preserved. Assert rst while count = 2 -> valido = 0, data_out = 0 immediately. After release, push 99 -> data_out = 99 and count = 1.
